// File: rtl/uart_rx_checked.sv
// uart_rx_checked
//   8N1 UART receiver, LSB first, CLKS_PER_BIT clocks per bit. Two-flop input
//   synchroniser, 3-sample majority vote per bit, false-start rejection,
//   framing-error and overrun detection, valid/ready output handshake.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   i_rx          raw serial line, idle high, asynchronous to clk
//   i_data_ready  consumer accepts o_data_byte while o_data_valid is high
//   o_data_valid  o_data_byte holds an unconsumed byte
//   o_data_byte   received byte, stable while o_data_valid is high
//   o_frame_err   one-clock pulse: stop bit sampled low
//   o_overrun     one-clock pulse: good frame dropped because output was full
//   o_busy        receiver is in any state other than IDLE
module uart_rx_checked #(
    parameter int unsigned CLKS_PER_BIT = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    input  logic       i_data_ready,
    output logic       o_data_valid,
    output logic [7:0] o_data_byte,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
);

    localparam int unsigned H  = CLKS_PER_BIT / 2;
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t CNT_S0   = cnt_t'(H - 1);
    localparam cnt_t CNT_S1   = cnt_t'(H);
    localparam cnt_t CNT_DEC  = cnt_t'(H + 1);
    localparam cnt_t CNT_LAST = cnt_t'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic       rx_meta_q;
    logic       rx_s_q;
    state_t     state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic [1:0] smp_q, smp_d;
    logic       valid_q, valid_d;
    logic [7:0] byte_q, byte_d;
    logic       ferr_q, ferr_d;
    logic       ovr_q, ovr_d;

    logic at_dec;
    logic at_last;
    logic maj;
    logic consume;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            smp_q   <= '0;
            valid_q <= 1'b0;
            byte_q  <= '0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            smp_q   <= smp_d;
            valid_q <= valid_d;
            byte_q  <= byte_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign at_dec  = (cnt_q == CNT_DEC);
    assign at_last = (cnt_q == CNT_LAST);
    // Third sample is the live rx_s at the decision count.
    assign maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);
    assign consume = valid_q & i_data_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        smp_d   = smp_q;
        valid_d = valid_q;
        byte_d  = byte_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        if (consume) begin
            valid_d = 1'b0;
        end

        if (cnt_q == CNT_S0) begin
            smp_d[0] = rx_s_q;
        end
        if (cnt_q == CNT_S1) begin
            smp_d[1] = rx_s_q;
        end

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d = at_last ? '0 : cnt_q + cnt_t'(1);
                if (at_dec && maj) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (at_last) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                cnt_d = at_last ? '0 : cnt_q + cnt_t'(1);
                if (at_dec) begin
                    shift_d = {maj, shift_q[7:1]};
                end
                if (at_last) begin
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                cnt_d = cnt_q + cnt_t'(1);
                if (at_dec) begin
                    cnt_d = '0;
                    if (maj) begin
                        // A byte being consumed on this edge frees the slot,
                        // so the new byte loads without overrun.
                        if (!valid_q || consume) begin
                            byte_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign o_data_valid = valid_q;
    assign o_data_byte  = byte_q;
    assign o_frame_err  = ferr_q;
    assign o_overrun    = ovr_q;
    assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_checked.sv
// tb_uart_rx_checked
//   Directed bench for uart_rx_checked at CLKS_PER_BIT = 200. A table of good
//   frames is replayed with the consumer always ready; hand-written sequences
//   cover glitches, framing error with a held-low line, overrun, stall release
//   on the load edge, and reset in the middle of a frame.
module tb_uart_rx_checked;

    localparam int unsigned CPB = 200;
    localparam int unsigned H   = CPB / 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_rx;
    logic       i_data_ready;
    logic       o_data_valid;
    logic [7:0] o_data_byte;
    logic       o_frame_err;
    logic       o_overrun;
    logic       o_busy;

    always #5 clk = ~clk;

    uart_rx_checked #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_rx         (i_rx),
        .i_data_ready (i_data_ready),
        .o_data_valid (o_data_valid),
        .o_data_byte  (o_data_byte),
        .o_frame_err  (o_frame_err),
        .o_overrun    (o_overrun),
        .o_busy       (o_busy)
    );

    int checks = 0;
    int errors = 0;

    // Event counters, sampled 2 time units after each falling edge so that
    // inputs driven on the falling edge are already settled.
    int         n_acc  = 0;
    int         n_ferr = 0;
    int         n_ovr  = 0;
    int         n_both = 0;
    logic [7:0] last_acc = 8'h00;

    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (o_data_valid && i_data_ready) begin
                n_acc++;
                last_acc = o_data_byte;
            end
            if (o_frame_err) n_ferr++;
            if (o_overrun) n_ovr++;
            if (o_frame_err && o_overrun) n_both++;
        end
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic bit_hold(input logic v, input int n);
        i_rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stopb);
        bit_hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) bit_hold(d[i], CPB);
        bit_hold(stopb, CPB);
    endtask

    typedef struct {
        logic [7:0] data;
        int         gap_bits;
        int         exp_acc;
        logic [7:0] exp_byte;
        int         exp_ferr;
        int         exp_ovr;
    } vec_t;

    vec_t vecs[7];

    int a0, f0, o0;

    initial begin
        vecs[0] = '{data: 8'h55, gap_bits: 1, exp_acc: 1, exp_byte: 8'h55, exp_ferr: 0, exp_ovr: 0};
        vecs[1] = '{data: 8'hAA, gap_bits: 0, exp_acc: 1, exp_byte: 8'hAA, exp_ferr: 0, exp_ovr: 0};
        vecs[2] = '{data: 8'h00, gap_bits: 0, exp_acc: 1, exp_byte: 8'h00, exp_ferr: 0, exp_ovr: 0};
        vecs[3] = '{data: 8'hFF, gap_bits: 2, exp_acc: 1, exp_byte: 8'hFF, exp_ferr: 0, exp_ovr: 0};
        vecs[4] = '{data: 8'h80, gap_bits: 1, exp_acc: 1, exp_byte: 8'h80, exp_ferr: 0, exp_ovr: 0};
        vecs[5] = '{data: 8'h01, gap_bits: 0, exp_acc: 1, exp_byte: 8'h01, exp_ferr: 0, exp_ovr: 0};
        vecs[6] = '{data: 8'h96, gap_bits: 1, exp_acc: 1, exp_byte: 8'h96, exp_ferr: 0, exp_ovr: 0};

        rst          = 1'b1;
        i_rx         = 1'b1;
        i_data_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_valid", int'(o_data_valid), 0);
        chk("reset_byte",  int'(o_data_byte), 8'h00);
        chk("reset_ferr",  int'(o_frame_err), 0);
        chk("reset_ovr",   int'(o_overrun), 0);
        chk("reset_busy",  int'(o_busy), 0);
        rst = 1'b0;
        bit_hold(1'b1, CPB);

        // Table of good frames, consumer always ready.
        i_data_ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            a0 = n_acc; f0 = n_ferr; o0 = n_ovr;
            send_frame(vecs[v].data, 1'b1);
            #1;
            chk($sformatf("vec%0d_acc", v),  n_acc - a0, vecs[v].exp_acc);
            chk($sformatf("vec%0d_byte", v), int'(last_acc), int'(vecs[v].exp_byte));
            chk($sformatf("vec%0d_ferr", v), n_ferr - f0, vecs[v].exp_ferr);
            chk($sformatf("vec%0d_ovr", v),  n_ovr - o0, vecs[v].exp_ovr);
            chk($sformatf("vec%0d_busy", v), int'(o_busy), 0);
            bit_hold(1'b1, vecs[v].gap_bits * CPB);
        end

        // 50-clock low pulse is a false start.
        a0 = n_acc; f0 = n_ferr; o0 = n_ovr;
        bit_hold(1'b0, 30);
        #1;
        chk("glitch50_busy_mid", int'(o_busy), 1);
        bit_hold(1'b0, 20);
        bit_hold(1'b1, H + 3);
        #1;
        chk("glitch50_busy_end", int'(o_busy), 0);
        bit_hold(1'b1, CPB);
        chk("glitch50_acc",  n_acc - a0, 0);
        chk("glitch50_ferr", n_ferr - f0, 0);
        chk("glitch50_ovr",  n_ovr - o0, 0);

        // 8'h0F with a one-clock inversion landing on the decision sample of bit 3.
        a0 = n_acc;
        bit_hold(1'b0, CPB);
        bit_hold(1'b1, CPB);
        bit_hold(1'b1, CPB);
        bit_hold(1'b1, CPB);
        bit_hold(1'b1, H + 2);
        bit_hold(1'b0, 1);
        bit_hold(1'b1, CPB - H - 3);
        for (int i = 0; i < 4; i++) bit_hold(1'b0, CPB);
        bit_hold(1'b1, CPB);
        #1;
        chk("glitchbit_acc",  n_acc - a0, 1);
        chk("glitchbit_byte", int'(last_acc), 8'h0F);
        bit_hold(1'b1, CPB);

        // Framing error, line held low for 20 bit times, then recovery.
        a0 = n_acc; f0 = n_ferr; o0 = n_ovr;
        send_frame(8'hA5, 1'b0);
        bit_hold(1'b0, 20 * CPB);
        #1;
        chk("break_busy", int'(o_busy), 1);
        bit_hold(1'b1, CPB);
        #1;
        chk("break_idle", int'(o_busy), 0);
        chk("ferr_count", n_ferr - f0, 1);
        chk("ferr_acc",   n_acc - a0, 0);
        chk("ferr_ovr",   n_ovr - o0, 0);
        a0 = n_acc;
        send_frame(8'h3C, 1'b1);
        bit_hold(1'b1, CPB);
        #1;
        chk("post_ferr_acc",  n_acc - a0, 1);
        chk("post_ferr_byte", int'(last_acc), 8'h3C);

        // Overrun with consumer stalled.
        i_data_ready = 1'b0;
        a0 = n_acc; f0 = n_ferr; o0 = n_ovr;
        send_frame(8'h11, 1'b1);
        bit_hold(1'b1, CPB);
        send_frame(8'h22, 1'b1);
        bit_hold(1'b1, CPB);
        #1;
        chk("ovr_valid", int'(o_data_valid), 1);
        chk("ovr_byte",  int'(o_data_byte), 8'h11);
        chk("ovr_count", n_ovr - o0, 1);
        chk("ovr_acc",   n_acc - a0, 0);
        chk("ovr_ferr",  n_ferr - f0, 0);
        i_data_ready = 1'b1;
        @(negedge clk);
        #1;
        i_data_ready = 1'b0;
        chk("ovr_release_valid", int'(o_data_valid), 0);
        chk("ovr_release_byte",  int'(o_data_byte), 8'h11);
        bit_hold(1'b1, CPB);

        // Back-to-back frames; ready raised exactly on the edge 8'h02 loads.
        // That edge is 2000 + 1905 rising edges after frame 1 starts.
        a0 = n_acc; o0 = n_ovr;
        fork
            begin
                send_frame(8'h01, 1'b1);
                send_frame(8'h02, 1'b1);
            end
            begin
                repeat (2 * 10 * CPB - 96) @(negedge clk);
                i_data_ready = 1'b1;
                @(negedge clk);
                i_data_ready = 1'b0;
            end
        join
        #1;
        chk("b2b_valid",    int'(o_data_valid), 1);
        chk("b2b_byte",     int'(o_data_byte), 8'h02);
        chk("b2b_ovr",      n_ovr - o0, 0);
        chk("b2b_acc",      n_acc - a0, 1);
        chk("b2b_acc_byte", int'(last_acc), 8'h01);

        // Reset during data bit 4 of 8'hC3.
        bit_hold(1'b0, CPB);
        bit_hold(1'b1, CPB);
        bit_hold(1'b1, CPB);
        bit_hold(1'b0, CPB);
        bit_hold(1'b0, CPB);
        bit_hold(1'b0, H);
        #1;
        chk("pre_rst_busy", int'(o_busy), 1);
        rst  = 1'b1;
        i_rx = 1'b1;
        #1;
        chk("rst_mid_valid", int'(o_data_valid), 0);
        chk("rst_mid_byte",  int'(o_data_byte), 8'h00);
        chk("rst_mid_ferr",  int'(o_frame_err), 0);
        chk("rst_mid_ovr",   int'(o_overrun), 0);
        chk("rst_mid_busy",  int'(o_busy), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bit_hold(1'b1, 2 * CPB);
        a0 = n_acc; f0 = n_ferr; o0 = n_ovr;
        i_data_ready = 1'b1;
        send_frame(8'hC3, 1'b1);
        bit_hold(1'b1, CPB);
        #1;
        chk("post_rst_acc",  n_acc - a0, 1);
        chk("post_rst_byte", int'(last_acc), 8'hC3);
        chk("post_rst_ferr", n_ferr - f0, 0);
        chk("post_rst_ovr",  n_ovr - o0, 0);

        chk("flags_exclusive", n_both, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
